// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, arbiter state encoding and watchdog sizing helper.
// Pure declarations; no latency or flow control.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, IACC, DACC, HIT} arbstate_t;

  localparam int DEFAULT_TIMEOUT = 64;

  // Watchdog width must hold the value TIMEOUT itself.
  function automatic int wdog_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for instruction/data requests, data wins ties; hit pulses one cycle
// after ramready (2-cycle minimum), requests are levels held until hit, watchdog aborts stuck RAM.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  ihit,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dhit,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready,
  output logic  memerr
);

  localparam int WDOG_W = wdog_width(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  arbstate_t         r_state;
  arbstate_t         w_next;
  logic [WDOG_W-1:0] r_wdog;
  logic              w_dreq;
  logic              w_timeout;

  assign w_dreq = dREN | dWEN;
  // Abort on the last permitted strobe cycle so the strobes stay high exactly TIMEOUT cycles.
  assign w_timeout = !ramready && (r_wdog == WDOG_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dreq)    w_next = DACC;
        else if (iREN) w_next = IACC;
      end
      IACC, DACC: begin
        if (ramready)       w_next = HIT;
        else if (w_timeout) w_next = IDLE;
      end
      HIT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      memerr   <= 1'b0;
      r_wdog   <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dreq) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= dREN & ~dWEN;
            r_wdog   <= '0;
          end else if (iREN) begin
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            r_wdog  <= '0;
          end
        end
        IACC, DACC: begin
          if (ramready) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (r_state == IACC) begin
              ihit  <= 1'b1;
              iload <= ramload;
            end else begin
              dhit <= 1'b1;
              if (!ramWEN) dload <= ramload;
            end
          end else if (w_timeout) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            memerr <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with TIMEOUT=4: single accesses, priority, writes,
// read+write collision, watchdog abort with sticky error, and mid-access reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  iREN, dREN, dWEN, ramready;
  word_t iaddr, daddr, dstore, ramload;
  logic  ihit, dhit, ramREN, ramWEN, memerr;
  word_t iload, dload, ramaddr, ramstore;

  int n_assert = 0;
  int n_fail   = 0;

  memory_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ihit"},   32'(ihit),   32'd0);
    check({tag, ".dhit"},   32'(dhit),   32'd0);
    check({tag, ".ramREN"}, 32'(ramREN), 32'd0);
    check({tag, ".ramWEN"}, 32'(ramWEN), 32'd0);
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    tick(); tick();

    // Reset state
    check_idle_outputs("rst");
    check("rst.memerr",   32'(memerr), 32'd0);
    check("rst.iload",    iload,       32'h0);
    check("rst.dload",    dload,       32'h0);
    check("rst.ramaddr",  ramaddr,     32'h0);
    check("rst.ramstore", ramstore,    32'h0);
    nRST = 1'b1;
    tick();

    // Instruction read, ramready in the first strobe cycle
    iREN = 1; iaddr = 32'h0000_0040;
    tick();
    check("i1.ramREN",  32'(ramREN), 32'd1);
    check("i1.ramWEN",  32'(ramWEN), 32'd0);
    check("i1.ramaddr", ramaddr,     32'h40);
    check("i1.ihit0",   32'(ihit),   32'd0);
    ramready = 1; ramload = 32'h2001_0005;
    tick();
    check("i1.ihit",    32'(ihit),   32'd1);
    check("i1.iload",   iload,       32'h2001_0005);
    check("i1.ramREN2", 32'(ramREN), 32'd0);
    iREN = 0; ramready = 0;
    tick();
    check_idle_outputs("i1.bubble");
    check("i1.iload_hold", iload, 32'h2001_0005);
    tick();
    check_idle_outputs("i1.idle");

    // Simultaneous iREN and dREN: data first, instruction after the bubble
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100;
    tick();
    check("pr.ramREN",  32'(ramREN), 32'd1);
    check("pr.ramaddr", ramaddr,     32'h100);
    ramready = 1; ramload = 32'hDEAD_BEEF;
    tick();
    check("pr.dhit",  32'(dhit), 32'd1);
    check("pr.ihit",  32'(ihit), 32'd0);
    check("pr.dload", dload,     32'hDEAD_BEEF);
    dREN = 0; ramready = 0;
    tick();
    check_idle_outputs("pr.bubble");
    tick();
    check("pr.i.ramREN",  32'(ramREN), 32'd1);
    check("pr.i.ramaddr", ramaddr,     32'h80);
    ramready = 1; ramload = 32'hCAFE_0001;
    tick();
    check("pr.i.ihit",  32'(ihit), 32'd1);
    check("pr.i.iload", iload,     32'hCAFE_0001);
    check("pr.i.dload", dload,     32'hDEAD_BEEF);
    iREN = 0; ramready = 0;
    tick(); tick();

    // Data write, ramready on the 4th strobe cycle (last cycle before the watchdog)
    dWEN = 1; daddr = 32'h200; dstore = 32'h1234_5678;
    tick();
    daddr = 32'h999; dstore = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wr.c%0d.ramWEN", c),   32'(ramWEN), 32'd1);
      check($sformatf("wr.c%0d.ramREN", c),   32'(ramREN), 32'd0);
      check($sformatf("wr.c%0d.ramaddr", c),  ramaddr,     32'h200);
      check($sformatf("wr.c%0d.ramstore", c), ramstore,    32'h1234_5678);
      if (c == 4) begin ramready = 1; ramload = 32'h5555_AAAA; end
      tick();
    end
    check("wr.dhit",   32'(dhit),   32'd1);
    check("wr.ramWEN", 32'(ramWEN), 32'd0);
    check("wr.dload",  dload,       32'hDEAD_BEEF);
    check("wr.memerr", 32'(memerr), 32'd0);
    dWEN = 0; ramready = 0;
    tick(); tick();

    // dREN and dWEN together behave as a write
    dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'hA5A5_A5A5;
    tick();
    check("rw.ramWEN",   32'(ramWEN), 32'd1);
    check("rw.ramREN",   32'(ramREN), 32'd0);
    check("rw.ramstore", ramstore,    32'hA5A5_A5A5);
    ramready = 1; ramload = 32'h1111_1111;
    tick();
    check("rw.dhit",  32'(dhit), 32'd1);
    check("rw.dload", dload,     32'hDEAD_BEEF);
    dREN = 0; dWEN = 0; ramready = 0;
    tick(); tick();

    // Watchdog abort: 4 strobe cycles, then memerr with no hit
    iREN = 1; iaddr = 32'h400;
    tick();
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wd.c%0d.ramREN", c), 32'(ramREN), 32'd1);
      check($sformatf("wd.c%0d.memerr", c), 32'(memerr), 32'd0);
      tick();
    end
    check("wd.ramREN", 32'(ramREN), 32'd0);
    check("wd.memerr", 32'(memerr), 32'd1);
    check("wd.ihit",   32'(ihit),   32'd0);
    iREN = 0;
    tick();
    check("wd.ihit2",   32'(ihit),   32'd0);
    check("wd.memerr2", 32'(memerr), 32'd1);
    iREN = 1; iaddr = 32'h44;
    tick();
    check("wd.ok.ramREN", 32'(ramREN), 32'd1);
    ramready = 1; ramload = 32'h0000_0055;
    tick();
    check("wd.ok.ihit",   32'(ihit),   32'd1);
    check("wd.ok.iload",  iload,       32'h55);
    check("wd.ok.memerr", 32'(memerr), 32'd1);
    iREN = 0; ramready = 0;
    tick(); tick();

    // Reset in the middle of a data access
    dREN = 1; daddr = 32'h500;
    tick();
    check("mr.ramREN", 32'(ramREN), 32'd1);
    nRST = 0;
    #1;
    check_idle_outputs("mr.async");
    check("mr.memerr",  32'(memerr), 32'd0);
    check("mr.ramaddr", ramaddr,     32'h0);
    check("mr.dload",   dload,       32'h0);
    check("mr.iload",   iload,       32'h0);
    dREN = 0;
    tick();
    nRST = 1;
    tick();
    check_idle_outputs("mr.after");
    iREN = 1; iaddr = 32'h600;
    tick();
    check("mr.i.ramREN",  32'(ramREN), 32'd1);
    check("mr.i.ramaddr", ramaddr,     32'h600);
    check("mr.i.dhit",    32'(dhit),   32'd0);
    ramready = 1; ramload = 32'h0000_0077;
    tick();
    check("mr.i.ihit",  32'(ihit), 32'd1);
    check("mr.i.iload", iload,     32'h77);
    check("mr.i.dhit2", 32'(dhit), 32'd0);
    iREN = 0; ramready = 0;
    tick();
    check("mr.i.ihit_drop", 32'(ihit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
